// File: rtl/layer_controller_pkg.sv
// Shared definitions for the layer sequencing logic: FSM encoding, default
// array/address sizing and configuration field widths.
package layer_controller_pkg;

   localparam int NUM_PE_DEFAULT = 16;
   localparam int ADDR_W_DEFAULT = 22;

   localparam int IFM_SIZE_W = 9;
   localparam int IFM_CH_W   = 11;
   localparam int KERNEL_W   = 2;
   localparam int NFILT_W    = 11;
   localparam int STRIDE_W   = 2;
   localparam int TNF_W      = 5;
   localparam int ROW_W      = 10;   // conv/row arithmetic, one bit wider than ifm_size
   localparam int GRP_W      = 12;   // filter counts with headroom for rounding up

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_ADV   = 3'd4,
      ST_DONE  = 3'd5
   } layer_state_t;

endpackage

// File: rtl/layer_controller_addr_gen.sv
// Layer geometry derived once per layer, plus the row/group accumulators
// that walk the tile descriptors. All address math wraps at 2^ADDR_W.
module layer_addr_gen
   import layer_controller_pkg::*;
#(
   parameter int NUM_PE = NUM_PE_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  adv,
   input  logic [IFM_SIZE_W-1:0] ifm_size,
   input  logic [KERNEL_W-1:0]   kernel_size,
   input  logic [NFILT_W-1:0]    num_filter,
   input  logic                  maxpool_mode,
   input  logic [STRIDE_W-1:0]   maxpool_stride,
   input  logic                  upsample_mode,
   input  logic [ADDR_W-1:0]     start_write_addr,
   input  logic [ADDR_W-1:0]     start_read_addr,
   output logic                  cfg_ok,
   output logic [IFM_SIZE_W-1:0] ofm_size,
   output logic [ADDR_W-1:0]     tile_rd_addr,
   output logic [ADDR_W-1:0]     tile_wr_addr,
   output logic [NFILT_W-1:0]    tile_filter_base,
   output logic [TNF_W-1:0]      tile_num_filter,
   output logic                  last_tile
);

   logic [ROW_W-1:0]      conv_c, rows_c;
   logic [STRIDE_W-1:0]   s_eff;
   logic                  pool_ok;
   logic [IFM_SIZE_W-1:0] ofm_c;
   logic [GRP_W-1:0]      groups_c;
   logic [ADDR_W-1:0]     rd_step_c, wr_row_step_c, grp_step_c;

   logic [ROW_W-1:0]      rows_m1_q, row_q;
   logic [GRP_W-1:0]      groups_m1_q, grp_q, remaining_q;
   logic [ADDR_W-1:0]     rd_step_q, wr_row_step_q, grp_step_q, wr_grp_base_q;
   logic                  last_row;

   // Layer geometry from the captured configuration; only consumed in LOAD.
   always_comb begin
      conv_c   = {1'b0, ifm_size} - ROW_W'(kernel_size) + ROW_W'(1);
      s_eff    = maxpool_mode ? maxpool_stride : STRIDE_W'(1);
      pool_ok  = (conv_c >= ROW_W'(2)) && (s_eff != '0);
      rows_c   = conv_c;
      if (maxpool_mode)
         rows_c = pool_ok ? ((conv_c - ROW_W'(2)) / ROW_W'(s_eff)) + ROW_W'(1) : '0;
      ofm_c    = conv_c[IFM_SIZE_W-1:0];
      if (maxpool_mode)
         ofm_c = rows_c[IFM_SIZE_W-1:0];
      else if (upsample_mode)
         ofm_c = {conv_c[IFM_SIZE_W-2:0], 1'b0};
      cfg_ok   = (num_filter != '0) && (kernel_size != '0) &&
                 (ifm_size >= IFM_SIZE_W'(kernel_size)) && (!maxpool_mode || pool_ok);
      groups_c = ({1'b0, num_filter} + GRP_W'(NUM_PE - 1)) / GRP_W'(NUM_PE);
      rd_step_c     = ADDR_W'(s_eff) * ADDR_W'(ifm_size);
      wr_row_step_c = upsample_mode ? ADDR_W'({ofm_c, 1'b0}) : ADDR_W'(ofm_c);
      grp_step_c    = ADDR_W'(NUM_PE) * ADDR_W'(ofm_c) * ADDR_W'(ofm_c);
   end

   assign last_row        = (row_q == rows_m1_q);
   assign last_tile       = last_row && (grp_q == groups_m1_q);
   assign tile_num_filter = (remaining_q >= GRP_W'(NUM_PE)) ? TNF_W'(NUM_PE)
                                                            : remaining_q[TNF_W-1:0];

   // Latch geometry in LOAD, then step row pointers (inner) and group base (outer) in ADV.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ofm_size         <= '0;
         rows_m1_q        <= '0;
         groups_m1_q      <= '0;
         rd_step_q        <= '0;
         wr_row_step_q    <= '0;
         grp_step_q       <= '0;
         row_q            <= '0;
         grp_q            <= '0;
         remaining_q      <= '0;
         wr_grp_base_q    <= '0;
         tile_rd_addr     <= '0;
         tile_wr_addr     <= '0;
         tile_filter_base <= '0;
      end else if (load) begin
         ofm_size         <= ofm_c;
         rows_m1_q        <= rows_c - ROW_W'(1);
         groups_m1_q      <= groups_c - GRP_W'(1);
         rd_step_q        <= rd_step_c;
         wr_row_step_q    <= wr_row_step_c;
         grp_step_q       <= grp_step_c;
         row_q            <= '0;
         grp_q            <= '0;
         remaining_q      <= {1'b0, num_filter};
         wr_grp_base_q    <= start_write_addr;
         tile_rd_addr     <= start_read_addr;
         tile_wr_addr     <= start_write_addr;
         tile_filter_base <= '0;
      end else if (adv) begin
         if (last_row) begin
            row_q            <= '0;
            grp_q            <= grp_q + GRP_W'(1);
            remaining_q      <= remaining_q - GRP_W'(NUM_PE);
            tile_filter_base <= tile_filter_base + NFILT_W'(NUM_PE);
            wr_grp_base_q    <= wr_grp_base_q + grp_step_q;
            tile_wr_addr     <= wr_grp_base_q + grp_step_q;
            tile_rd_addr     <= start_read_addr;
         end else begin
            row_q        <= row_q + ROW_W'(1);
            tile_rd_addr <= tile_rd_addr + rd_step_q;
            tile_wr_addr <= tile_wr_addr + wr_row_step_q;
         end
      end
   end

endmodule

// File: rtl/layer_controller.sv
// Runs one layer: captures its configuration, then issues one tile per
// (filter group, output row) to the PE array and reports completion.
//
// Handshake: start_layer is a one-cycle request honoured only in IDLE;
// tile_start is a one-cycle launch, the descriptor stays frozen until the
// engine answers with a one-cycle tile_done, which is honoured only in WAIT.
module layer_controller
   import layer_controller_pkg::*;
#(
   parameter int NUM_PE = NUM_PE_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_layer,
   input  logic [IFM_SIZE_W-1:0] ifm_size,
   input  logic [IFM_CH_W-1:0]   ifm_channel,
   input  logic [KERNEL_W-1:0]   kernel_size,
   input  logic [NFILT_W-1:0]    num_filter,
   input  logic                  maxpool_mode,
   input  logic [STRIDE_W-1:0]   maxpool_stride,
   input  logic                  upsample_mode,
   input  logic [ADDR_W-1:0]     start_write_addr,
   input  logic [ADDR_W-1:0]     start_read_addr,
   output logic                  tile_start,
   input  logic                  tile_done,
   output logic [ADDR_W-1:0]     tile_rd_addr,
   output logic [ADDR_W-1:0]     tile_wr_addr,
   output logic [NFILT_W-1:0]    tile_filter_base,
   output logic [TNF_W-1:0]      tile_num_filter,
   output logic [IFM_SIZE_W-1:0] ifm_size_q,
   output logic [IFM_CH_W-1:0]   ifm_channel_q,
   output logic [KERNEL_W-1:0]   kernel_size_q,
   output logic                  maxpool_mode_q,
   output logic [STRIDE_W-1:0]   maxpool_stride_q,
   output logic                  upsample_mode_q,
   output logic [IFM_SIZE_W-1:0] ofm_size,
   output logic                  busy,
   output logic                  done_layer,
   output layer_state_t          state_dbg
);

   layer_state_t         state_q, state_d;
   logic [NFILT_W-1:0]   num_filter_q;
   logic [ADDR_W-1:0]    start_wr_q, start_rd_q;
   logic                 cfg_ok, last_tile, accept;

   assign accept    = (state_q == ST_IDLE) && start_layer;
   assign state_dbg = state_q;

   // Configuration is captured only when a request is accepted in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifm_size_q       <= '0;
         ifm_channel_q    <= '0;
         kernel_size_q    <= '0;
         num_filter_q     <= '0;
         maxpool_mode_q   <= 1'b0;
         maxpool_stride_q <= '0;
         upsample_mode_q  <= 1'b0;
         start_wr_q       <= '0;
         start_rd_q       <= '0;
      end else if (accept) begin
         ifm_size_q       <= ifm_size;
         ifm_channel_q    <= ifm_channel;
         kernel_size_q    <= kernel_size;
         num_filter_q     <= num_filter;
         maxpool_mode_q   <= maxpool_mode;
         maxpool_stride_q <= maxpool_stride;
         upsample_mode_q  <= upsample_mode;
         start_wr_q       <= start_write_addr;
         start_rd_q       <= start_read_addr;
      end
   end

   // State register; pulses are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tile_start <= 1'b0;
         done_layer <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         tile_start <= (state_d == ST_ISSUE);
         done_layer <= (state_d == ST_DONE);
         busy       <= (state_d != ST_IDLE);
      end
   end

   // Next-state: group/row loop driven by the address generator's last-tile flag.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_layer) state_d = ST_LOAD;
         ST_LOAD:  state_d = cfg_ok ? ST_ISSUE : ST_DONE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (tile_done) state_d = ST_ADV;
         ST_ADV:   state_d = last_tile ? ST_DONE : ST_ISSUE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   layer_addr_gen #(
      .NUM_PE (NUM_PE),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk              (clk),
      .rst_n            (rst_n),
      .load             (state_q == ST_LOAD),
      .adv              (state_q == ST_ADV),
      .ifm_size         (ifm_size_q),
      .kernel_size      (kernel_size_q),
      .num_filter       (num_filter_q),
      .maxpool_mode     (maxpool_mode_q),
      .maxpool_stride   (maxpool_stride_q),
      .upsample_mode    (upsample_mode_q),
      .start_write_addr (start_wr_q),
      .start_read_addr  (start_rd_q),
      .cfg_ok           (cfg_ok),
      .ofm_size         (ofm_size),
      .tile_rd_addr     (tile_rd_addr),
      .tile_wr_addr     (tile_wr_addr),
      .tile_filter_base (tile_filter_base),
      .tile_num_filter  (tile_num_filter),
      .last_tile        (last_tile)
   );

endmodule

// File: doc/layer_controller.md
LAYER_CONTROLLER -- requirements
Module: layer_controller

Interface
REQ-001 SHALL have parameters: NUM_PE, default 16, filters computed per pass; ADDR_W, default 22, OFM RAM address width.
REQ-002 SHALL have port clk, input, 1, clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start_layer, input, 1, one-cycle request to run a layer.
REQ-005 SHALL have config inputs, sampled only on an accepted start_layer: ifm_size 9, ifm_channel 11, kernel_size 2, num_filter 11, maxpool_mode 1, maxpool_stride 2, upsample_mode 1, start_write_addr ADDR_W, start_read_addr ADDR_W.
REQ-006 SHALL have port tile_start, output, 1, one-cycle pulse launching one tile on the PE array.
REQ-007 SHALL have port tile_done, input, 1, engine completion pulse for the current tile.
REQ-008 SHALL have tile descriptor outputs, held stable from tile_start until tile_done: tile_rd_addr ADDR_W, tile_wr_addr ADDR_W, tile_filter_base 11, tile_num_filter 5.
REQ-009 SHALL have layer register outputs: ifm_size_q, ifm_channel_q, kernel_size_q, maxpool_mode_q, maxpool_stride_q, upsample_mode_q, and ofm_size 9.
REQ-010 SHALL have port busy, output, 1, high from acceptance until done_layer.
REQ-011 SHALL have port done_layer, output, 1, registered one-cycle pulse when the layer completes.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, ISSUE, WAIT, ADV, DONE.
REQ-013 IDLE with start_layer=1 SHALL capture the config and go to LOAD; start_layer outside IDLE SHALL be ignored.
REQ-014 LOAD SHALL take exactly one cycle and compute:
  - conv = ifm_size-kernel_size+1
  - S = maxpool_stride if maxpool_mode, else 1
  - rows = (conv-2)/S+1 if maxpool_mode, else conv
  - ofm_size = rows if maxpool_mode; 2*conv if upsample_mode; otherwise conv
  - groups = ceil(num_filter/NUM_PE)
  - grp_step = NUM_PE*ofm_size*ofm_size
REQ-015 LOAD SHALL go to DONE without issuing any tile if num_filter=0, kernel_size=0, ifm_size<kernel_size, or maxpool_mode with conv<2 or S=0.
REQ-016 ISSUE SHALL pulse tile_start for one cycle and go to WAIT.
REQ-017 WAIT SHALL go to ADV on tile_done; tile_done in any other state SHALL be ignored.
REQ-018 Iteration SHALL have filter group g as the outer loop and output row r as the inner loop, each starting at 0.
REQ-019 Tile descriptor values:
  - tile_rd_addr = start_read_addr + r*S*ifm_size
  - tile_wr_addr = start_write_addr + g*grp_step + r*ofm_size*(upsample_mode?2:1)
  - tile_filter_base = g*NUM_PE
  - tile_num_filter = min(NUM_PE, num_filter-g*NUM_PE)
REQ-020 Addresses SHALL be produced by running accumulators (add-only in ADV); arithmetic SHALL be modulo 2^ADDR_W.
REQ-021 ADV SHALL advance r; at r=rows-1 it SHALL reset r, advance g and reload the row pointers; after the last tile (g=groups-1, r=rows-1) it SHALL go to DONE, otherwise to ISSUE.
REQ-022 DONE SHALL pulse done_layer for exactly one cycle, clear busy and return to IDLE; done_layer SHALL be low at all other times so the upstream falling-edge layer counter increments once per layer.
REQ-023 start_layer in the DONE cycle SHALL be ignored; the next layer SHALL be accepted from IDLE at the earliest one cycle later.
REQ-024 tile_start-to-tile_start latency SHALL be 3 cycles plus the engine latency: ISSUE, WAIT (at least 1 cycle), ADV.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE and clear all outputs, counters and captured config to 0, including mid-layer; any in-flight tile_done SHALL be discarded.

Structure
REQ-026 The FSM state encoding, NUM_PE and ADDR_W defaults and the config field widths SHALL reside in a shared package, also used by main_controller.
REQ-027 One sub-module, layer_addr_gen, SHALL hold the LOAD arithmetic and the row/group address accumulators; the FSM SHALL remain in layer_controller.

Verification
REQ-028 ifm 110, ch 16, k3, 16 filters, maxpool s2, rd 0, wr 193600 -> ofm 54; 54 tiles; rd step 220; wr step 54; one done_layer after the 54th tile_done.
REQ-029 ifm 5, k3, 16 filters, maxpool s1 -> ofm 2; 2 tiles; rd addrs base, base+5; wr addrs base, base+2.
REQ-030 ifm 13, k1, 255 filters, no pool, wr 1730560 -> 16 groups x 13 rows = 208 tiles; group wr step 2704; last tile_num_filter 15, tile_filter_base 240.
REQ-031 ifm 13, k1, 128 filters, upsample -> ofm 26; 104 tiles; row wr step 52; group wr step 10816.
REQ-032 num_filter 0 -> no tile_start; done_layer 2 cycles after start_layer.
REQ-033 rst_n low during tile 5 WAIT -> IDLE, outputs 0, late tile_done ignored; start_layer pulse while busy -> no effect.
